pwm_phase_generator: RTL

- Multi-channel, parametrised successor to the single fixed-rate switch PWM.
- Generates NUM_CH phase-offset PWM channels from one shared period counter. Each channel drives a complementary output pair with programmable dead time.
- Period, duty, phase and dead time are loaded through a valid/ready config port. New settings take effect only at a period boundary, so no output pulse is ever truncated.
- Drives the PMOD switch outputs. Defaults reproduce 2.083 kHz, 50 % duty from the 100 MHz clock.

---
 rtl/pwm_phase_generator.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/pwm_phase_generator.sv
// Multi-channel phase-offset PWM with complementary outputs and dead-time insertion.
// All channels share one period counter; new settings land only on a period boundary.
module pwm_phase_generator #(
  parameter int unsigned NUM_CH         = 2,
  parameter int unsigned CNT_W          = 16,
  parameter int unsigned DEAD_W         = 8,
  parameter int unsigned DEFAULT_PERIOD = 47999,
  parameter int unsigned DEFAULT_HIGH   = 24000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic                    cfg_valid,
  output logic                    cfg_ready,
  input  logic [CNT_W-1:0]        cfg_period,
  input  logic [CNT_W-1:0]        cfg_high,
  input  logic [NUM_CH*CNT_W-1:0] cfg_phase,
  input  logic [DEAD_W-1:0]       cfg_dead,
  output logic [NUM_CH-1:0]       pwm,
  output logic [NUM_CH-1:0]       pwm_n,
  output logic                    period_tick
);

  localparam logic [CNT_W-1:0] DefPeriod = CNT_W'(DEFAULT_PERIOD);
  localparam logic [CNT_W-1:0] DefHigh   = CNT_W'(DEFAULT_HIGH);

  // Period counter and run tracking
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             run_q;
  logic             counting, restart, wrap;

  // Active configuration
  logic [CNT_W-1:0]        per_q, high_q;
  logic [NUM_CH*CNT_W-1:0] phase_q;
  logic [DEAD_W-1:0]       dead_q;

  // Pending configuration
  logic                    pend_q;
  logic [CNT_W-1:0]        pend_per_q, pend_high_q;
  logic [NUM_CH*CNT_W-1:0] pend_phase_q;
  logic [DEAD_W-1:0]       pend_dead_q;
  logic                    accept, apply;

  // Compare stage
  logic [CNT_W-1:0]  ph_eff [NUM_CH];
  logic [CNT_W-1:0]  pos    [NUM_CH];
  logic [NUM_CH-1:0] raw_q, raw_d;

  // Dead-time output stage
  logic [NUM_CH-1:0]             lvl_q, lvl_d;
  logic [NUM_CH-1:0][DEAD_W-1:0] dcnt_q, dcnt_d;
  logic [NUM_CH-1:0]             pwm_q, pwm_d;
  logic [NUM_CH-1:0]             pwm_n_q, pwm_n_d;
  logic                          tick_q;

  always_comb begin : ctrl
    counting = enable & run_q;
    // First enabled cycle after idle: counter stays at 0, outputs enter a fresh dead window
    restart  = enable & ~run_q;
    wrap     = counting & (cnt_q == per_q);
    accept   = cfg_valid & ~pend_q;
    apply    = pend_q & (~enable | wrap);
    cnt_d    = (counting && !wrap) ? cnt_q + CNT_W'(1) : '0;
  end

  always_comb begin : position
    for (int k = 0; k < NUM_CH; k++) begin
      ph_eff[k] = phase_q[k*CNT_W +: CNT_W];
      if (ph_eff[k] > per_q) begin
        ph_eff[k] = '0;
      end
      // The wrapped sum needs CNT_W+1 bits so P = 2^CNT_W - 1 cannot overflow
      if (cnt_q >= ph_eff[k]) begin
        pos[k] = cnt_q - ph_eff[k];
      end else begin
        pos[k] = CNT_W'({1'b0, cnt_q} + {1'b0, per_q} + (CNT_W+1)'(1) - {1'b0, ph_eff[k]});
      end
      raw_d[k] = counting & (pos[k] < high_q);
    end
  end

  always_comb begin : dead_time
    pwm_d   = '0;
    pwm_n_d = '0;
    lvl_d   = lvl_q;
    dcnt_d  = dcnt_q;
    for (int k = 0; k < NUM_CH; k++) begin
      if (!enable) begin
        lvl_d[k]  = 1'b0;
        dcnt_d[k] = '0;
      end else if (restart || (raw_q[k] != lvl_q[k])) begin
        // Any level change (or a restart) opens a full window; a change inside one restarts it
        lvl_d[k] = raw_q[k] & ~restart;
        if (dead_q == '0) begin
          pwm_d[k]   = raw_q[k] & ~restart;
          pwm_n_d[k] = ~(raw_q[k] & ~restart);
          dcnt_d[k]  = '0;
        end else begin
          dcnt_d[k] = dead_q;
        end
      end else if (dcnt_q[k] != '0) begin
        dcnt_d[k] = dcnt_q[k] - DEAD_W'(1);
        if (dcnt_q[k] == DEAD_W'(1)) begin
          pwm_d[k]   = lvl_q[k];
          pwm_n_d[k] = ~lvl_q[k];
        end
      end else begin
        pwm_d[k]   = lvl_q[k];
        pwm_n_d[k] = ~lvl_q[k];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      run_q   <= 1'b0;
      raw_q   <= '0;
      lvl_q   <= '0;
      dcnt_q  <= '0;
      pwm_q   <= '0;
      pwm_n_q <= '0;
      tick_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      run_q   <= enable;
      raw_q   <= raw_d;
      lvl_q   <= lvl_d;
      dcnt_q  <= dcnt_d;
      pwm_q   <= pwm_d;
      pwm_n_q <= pwm_n_d;
      tick_q  <= wrap;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      per_q        <= DefPeriod;
      high_q       <= DefHigh;
      phase_q      <= '0;
      dead_q       <= '0;
      pend_q       <= 1'b0;
      pend_per_q   <= '0;
      pend_high_q  <= '0;
      pend_phase_q <= '0;
      pend_dead_q  <= '0;
    end else if (apply) begin
      per_q   <= pend_per_q;
      high_q  <= pend_high_q;
      phase_q <= pend_phase_q;
      dead_q  <= pend_dead_q;
      pend_q  <= 1'b0;
    end else if (accept) begin
      pend_q       <= 1'b1;
      pend_per_q   <= cfg_period;
      pend_high_q  <= cfg_high;
      pend_phase_q <= cfg_phase;
      pend_dead_q  <= cfg_dead;
    end
  end

  assign cfg_ready   = ~pend_q;
  assign pwm         = pwm_q;
  assign pwm_n       = pwm_n_q;
  assign period_tick = tick_q;

endmodule
